// File: rtl/instr_encode.sv
// RV32I instruction encoder feeding a 2-entry {instr, addr} output FIFO.
// Optional immediate range checking is enabled by defining INSTR_ENCODE_RANGE_CHECK_EN.
module instr_encode #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic        err_range,
    output logic [15:0] count
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [3:0] {
        C_R, C_I, C_SH, C_B, C_J, C_JALR, C_U, C_S, C_L, C_CSR, C_FENCE, C_FIXED, C_ILL
    } cls_t;

    cls_t        w_cls;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [6:0]  w_opc;
    logic [31:0] w_fixed;
    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_range_bad;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_new_addr;

    logic [1:0]        r_occ;
    logic [31:0]       r_slot0_instr, r_slot0_addr;
    logic [31:0]       r_slot1_instr, r_slot1_addr;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_count;
    logic              r_err_illegal;

    // Decode op_sel into format class, funct3, alternate-funct7 flag and major opcode.
    always_comb begin
        w_cls   = C_ILL;
        w_f3    = 3'd0;
        w_alt   = 1'b0;
        w_opc   = 7'b0010011;
        w_fixed = 32'h0000_0013;
        case (op_sel)
            6'd0:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd0; end
            6'd1:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd0; w_alt = 1'b1; end
            6'd2:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd1; end
            6'd3:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd2; end
            6'd4:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd3; end
            6'd5:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd4; end
            6'd6:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd6; end
            6'd7:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd7; end
            6'd8:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd5; end
            6'd9:  begin w_cls = C_R;  w_opc = 7'b0110011; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd10: begin w_cls = C_I;  w_f3 = 3'd0; end
            6'd11: begin w_cls = C_I;  w_f3 = 3'd2; end
            6'd12: begin w_cls = C_I;  w_f3 = 3'd3; end
            6'd13: begin w_cls = C_I;  w_f3 = 3'd4; end
            6'd14: begin w_cls = C_I;  w_f3 = 3'd6; end
            6'd15: begin w_cls = C_I;  w_f3 = 3'd7; end
            6'd16: begin w_cls = C_SH; w_f3 = 3'd1; end
            6'd17: begin w_cls = C_SH; w_f3 = 3'd5; end
            6'd18: begin w_cls = C_SH; w_f3 = 3'd5; w_alt = 1'b1; end
            6'd19: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd0; end
            6'd20: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd1; end
            6'd21: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd4; end
            6'd22: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd5; end
            6'd23: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd6; end
            6'd24: begin w_cls = C_B;  w_opc = 7'b1100011; w_f3 = 3'd7; end
            6'd25: begin w_cls = C_J;    w_opc = 7'b1101111; end
            6'd26: begin w_cls = C_JALR; w_opc = 7'b1100111; end
            6'd27: begin w_cls = C_U;    w_opc = 7'b0110111; end
            6'd28: begin w_cls = C_U;    w_opc = 7'b0010111; end
            6'd29: begin w_cls = C_S;  w_opc = 7'b0100011; w_f3 = 3'd0; end
            6'd30: begin w_cls = C_S;  w_opc = 7'b0100011; w_f3 = 3'd1; end
            6'd31: begin w_cls = C_S;  w_opc = 7'b0100011; w_f3 = 3'd2; end
            6'd32: begin w_cls = C_L;  w_opc = 7'b0000011; w_f3 = 3'd0; end
            6'd33: begin w_cls = C_L;  w_opc = 7'b0000011; w_f3 = 3'd1; end
            6'd34: begin w_cls = C_L;  w_opc = 7'b0000011; w_f3 = 3'd2; end
            6'd35: begin w_cls = C_L;  w_opc = 7'b0000011; w_f3 = 3'd4; end
            6'd36: begin w_cls = C_L;  w_opc = 7'b0000011; w_f3 = 3'd5; end
            6'd37: begin w_cls = C_FIXED; w_fixed = 32'h0000_0073; end
            6'd38: begin w_cls = C_FIXED; w_fixed = 32'h0010_0073; end
            6'd39: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd1; end
            6'd40: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd2; end
            6'd41: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd3; end
            6'd42: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd5; end
            6'd43: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd6; end
            6'd44: begin w_cls = C_CSR; w_opc = 7'b1110011; w_f3 = 3'd7; end
            6'd45: begin w_cls = C_FENCE; w_opc = 7'b0001111; end
            6'd46: begin w_cls = C_FIXED; w_fixed = 32'h0000_100F; end
            default: begin w_cls = C_ILL; end
        endcase
    end

    // Assemble the 32-bit word from the decoded class; out-of-range fields are simply truncated.
    always_comb begin
        w_word    = 32'h0000_0013;
        w_illegal = 1'b0;
        case (w_cls)
            C_R:     w_word = {1'b0, w_alt, 5'b0, rs2, rs1, w_f3, rd, w_opc};
            C_I, C_L, C_JALR, C_CSR:
                     w_word = {imm[11:0], rs1, w_f3, rd, w_opc};
            C_SH:    w_word = {1'b0, w_alt, 5'b0, imm[4:0], rs1, w_f3, rd, w_opc};
            C_B:     w_word = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], w_opc};
            C_J:     w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, w_opc};
            C_U:     w_word = {imm[31:12], rd, w_opc};
            C_S:     w_word = {imm[11:5], rs2, rs1, w_f3, imm[4:0], w_opc};
            C_FENCE: w_word = {4'b0, imm[7:0], 5'b0, 3'b0, 5'b0, w_opc};
            C_FIXED: w_word = w_fixed;
            default: begin
                w_word    = 32'h0000_0013;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    logic r_err_range;
    always_comb begin
        w_range_bad = 1'b0;
        case (w_cls)
            C_I, C_L, C_JALR, C_S: w_range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            C_B:     w_range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            C_J:     w_range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            C_U:     w_range_bad = |imm[11:0];
            C_SH:    w_range_bad = |imm[31:5];
            C_FENCE: w_range_bad = |imm[31:8];
            default: w_range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_range <= 1'b0;
        end else if (w_push && w_range_bad) begin
            r_err_range <= 1'b1;
        end
    end
    assign err_range = r_err_range;
`else
    assign w_range_bad = 1'b0;
    assign err_range   = w_range_bad;
`endif

    assign in_ready   = !rst && (r_occ != 2'd2);
    assign out_valid  = (r_occ != 2'd0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_new_addr = BASE_ADDR + (32'(r_idx) << 2);

    // Shift-register FIFO: slot0 is always the head, so the outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ         <= 2'd0;
            r_slot0_instr <= 32'h0;
            r_slot0_addr  <= 32'h0;
            r_slot1_instr <= 32'h0;
            r_slot1_addr  <= 32'h0;
            r_idx         <= '0;
            r_count       <= 16'h0;
            r_err_illegal <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_slot0_instr <= w_word;
                        r_slot0_addr  <= w_new_addr;
                    end else begin
                        r_slot1_instr <= w_word;
                        r_slot1_addr  <= w_new_addr;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_slot0_instr <= r_slot1_instr;
                    r_slot0_addr  <= r_slot1_addr;
                    r_occ         <= r_occ - 2'd1;
                end
                2'b11: begin
                    r_slot0_instr <= w_word;
                    r_slot0_addr  <= w_new_addr;
                end
                default: ;
            endcase
            if (w_push) begin
                r_idx <= r_idx + 1'b1;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
                if (w_illegal) begin
                    r_err_illegal <= 1'b1;
                end
            end
        end
    end

    assign out_instr   = r_slot0_instr;
    assign out_addr    = r_slot0_addr;
    assign count       = r_count;
    assign err_illegal = r_err_illegal;

endmodule

// File: tb/tb_instr_encode.sv
// Directed-vector bench for instr_encode with hand-computed encodings and addresses.
// Instance uses BASE_ADDR=0x1000 and DEPTH_WORDS=4 so address wrap is exercised early.
module tb_instr_encode;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  op_sel = 6'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [31:0] imm = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_addr;
    logic        err_illegal, err_range;
    logic [15:0] count;

    int vectors = 0;
    int miscompares = 0;

    instr_encode #(.BASE_ADDR(BASE), .DEPTH_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_range(err_range), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [5:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        op_sel = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        $display("xfer %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h", tag, op, d, s1, s2, im);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".addr"}, out_addr, addr);
    endtask

    initial begin
        // Reset with a request pending: it must not be accepted.
        in_valid = 1'b1;
        step();
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.out_instr", out_instr, 32'h0);
        chk("rst.out_addr", out_addr, 32'h0);
        chk("rst.count", {16'b0, count}, 32'd0);
        chk("rst.err_illegal", {31'b0, err_illegal}, 32'd0);
        chk("rst.err_range", {31'b0, err_range}, 32'd0);

        // Streaming with out_ready=1: each word visible one cycle after accept.
        out_ready = 1'b1;
        send("addi", 6'd10, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_out("addi", 32'h0050_0093, BASE + 32'h0);
        send("sub", 6'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        chk_out("sub", 32'h4020_81B3, BASE + 32'h4);
        send("beq", 6'd19, 5'd0, 5'd1, 5'd2, -32'sd4);
        chk_out("beq", 32'hFE20_8EE3, BASE + 32'h8);
        send("jal", 6'd25, 5'd1, 5'd0, 5'd0, 32'd8);
        chk_out("jal", 32'h0080_00EF, BASE + 32'hC);
        send("lui", 6'd27, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        chk_out("lui", 32'h1234_52B7, BASE + 32'h0);
        send("sw", 6'd31, 5'd0, 5'd2, 5'd8, 32'd12);
        chk_out("sw", 32'h0081_2623, BASE + 32'h4);
        chk("wrap.count", {16'b0, count}, 32'd6);
        send("lw", 6'd34, 5'd10, 5'd2, 5'd0, 32'd8);
        chk_out("lw", 32'h0081_2503, BASE + 32'h8);
        send("srai", 6'd18, 5'd1, 5'd1, 5'd0, 32'd3);
        chk_out("srai", 32'h4030_D093, BASE + 32'hC);
        send("csrrw", 6'd39, 5'd1, 5'd2, 5'd0, 32'h300);
        chk_out("csrrw", 32'h3001_10F3, BASE + 32'h0);
        send("fence", 6'd45, 5'd0, 5'd0, 5'd0, 32'hFF);
        chk_out("fence", 32'h0FF0_000F, BASE + 32'h4);
        send("ecall", 6'd37, 5'd0, 5'd0, 5'd0, 32'd0);
        chk_out("ecall", 32'h0000_0073, BASE + 32'h8);
        send("ebreak", 6'd38, 5'd0, 5'd0, 5'd0, 32'd0);
        chk_out("ebreak", 32'h0010_0073, BASE + 32'hC);
        send("fence_i", 6'd46, 5'd0, 5'd0, 5'd0, 32'd0);
        chk_out("fence_i", 32'h0000_100F, BASE + 32'h0);
        step();
        chk("drain.out_valid", {31'b0, out_valid}, 32'd0);
        chk("legal.err_illegal", {31'b0, err_illegal}, 32'd0);
        chk("legal.err_range", {31'b0, err_range}, 32'd0);

        // Backpressure: two words fill the FIFO, third is held off.
        out_ready = 1'b0;
        send("bp_x", 6'd10, 5'd2, 5'd0, 5'd0, 32'd1);
        send("bp_y", 6'd10, 5'd3, 5'd0, 5'd0, 32'd2);
        op_sel = 6'd10; rd = 5'd4; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd3;
        in_valid = 1'b1;
        chk("bp.full.in_ready", {31'b0, in_ready}, 32'd0);
        chk_out("bp.head_x", 32'h0010_0113, BASE + 32'h4);
        step();
        chk_out("bp.hold_x", 32'h0010_0113, BASE + 32'h4);
        chk("bp.hold.in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk_out("bp.head_y", 32'h0020_0193, BASE + 32'h8);
        chk("bp.one.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        $display("xfer bp_z op=10 rd=4 rs1=0 rs2=0 imm=00000003");
        chk_out("bp.head_z", 32'h0030_0213, BASE + 32'hC);
        step();
        chk("bp.empty.out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp.count", {16'b0, count}, 32'd16);

        // Illegal op: NOP emitted, sticky flag.
        send("illegal", 6'd50, 5'd7, 5'd7, 5'd7, 32'd9);
        chk_out("illegal", 32'h0000_0013, BASE + 32'h0);
        chk("illegal.flag", {31'b0, err_illegal}, 32'd1);
        step();
        chk("illegal.sticky", {31'b0, err_illegal}, 32'd1);

        // Out-of-range I immediate: truncated encoding, flag only with range check.
        send("addi_big", 6'd10, 5'd0, 5'd0, 5'd0, 32'd2048);
        chk_out("addi_big", 32'h8000_0013, BASE + 32'h4);
        step();
        chk("range.flag", {31'b0, err_range}, {31'b0, RANGE_EN});
        chk("range.count", {16'b0, count}, 32'd18);

        // Reset mid-stream with words buffered and a request pending.
        out_ready = 1'b0;
        send("pre_rst_a", 6'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        send("pre_rst_b", 6'd5, 5'd1, 5'd2, 5'd3, 32'd0);
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("mid_rst.in_ready", {31'b0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("mid_rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst.out_instr", out_instr, 32'h0);
        chk("mid_rst.out_addr", out_addr, 32'h0);
        chk("mid_rst.count", {16'b0, count}, 32'd0);
        chk("mid_rst.err_illegal", {31'b0, err_illegal}, 32'd0);
        chk("mid_rst.err_range", {31'b0, err_range}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        send("post_rst", 6'd10, 5'd1, 5'd0, 5'd0, 32'd5);
        chk_out("post_rst", 32'h0050_0093, BASE + 32'h0);
        step();
        chk("post_rst.count", {16'b0, count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
